// File: rtl/fu_scoreboard.sv
// fu_scoreboard: issue hazard checks and writeback scheduling for five functional units.
// Define FU_SB_STALL_CNT_EN to build the saturating stall cycle counter.
module fu_scoreboard #(
   parameter int ALU_LAT = 1,
   parameter int MEM_LAT = 2,
   parameter int MUL_LAT = 7,
   parameter int DIV_LAT = 24,
   parameter int JUMP_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        issue_valid,
   input  logic [2:0]  issue_fu,
   input  logic [4:0]  issue_rd,
   input  logic        issue_wr,
   input  logic [4:0]  issue_rs1,
   input  logic [4:0]  issue_rs2,
   input  logic        issue_use_rs1,
   input  logic        issue_use_rs2,
   output logic        issue_ok,
   output logic [4:0]  fu_en,
   output logic [4:0]  busy,
   output logic        wb_we,
   output logic [2:0]  wb_sel,
   output logic [4:0]  wb_rd,
   output logic [31:0] stall_cnt
);
   localparam logic [4:0][4:0] LATS = {5'(JUMP_LAT), 5'(DIV_LAT), 5'(MUL_LAT), 5'(MEM_LAT), 5'(ALU_LAT)};
   logic [4:0][4:0] cnt;
   logic [4:0][4:0] rd_q;
   logic [4:0]      wr_q;
   logic [31:0]     pend;
   logic [31:0]     resv;
   logic            fu_ok;
   logic            cand_wr;
   logic            acc_wr;
   logic            raw;
   logic            waw;
   logic            port_busy;
   logic [2:0]      idx;
   logic [4:0]      lat_sel;

   assign fu_ok     = issue_fu >= 3'd1 && issue_fu <= 3'd5;
   assign idx       = fu_ok ? issue_fu - 3'd1 : 3'd0;
   assign lat_sel   = LATS[idx];
   assign cand_wr   = issue_wr && issue_rd != 5'd0;
   assign raw       = (issue_use_rs1 && pend[issue_rs1]) || (issue_use_rs2 && pend[issue_rs2]);
   assign waw       = issue_wr && pend[issue_rd];
   // resv[k] marks a writeback k cycles ahead, so the port is checked at our own latency
   assign port_busy = cand_wr && resv[lat_sel];
   assign issue_ok  = rst && issue_valid && fu_ok && cnt[idx] <= 5'd1 && !raw && !waw && !port_busy;
   assign acc_wr    = issue_ok && cand_wr;
   assign fu_en     = issue_ok ? 5'd1 << idx : 5'd0;

   always_comb begin
      busy   = '0;
      wb_we  = 1'b0;
      wb_sel = 3'd0;
      wb_rd  = 5'd0;
      for (int i = 0; i < 5; i++) begin
         busy[i] = cnt[i] != 5'd0;
         if (cnt[i] == 5'd1 && wr_q[i]) begin
            wb_we  = 1'b1;
            wb_sel = 3'(i + 1);
            wb_rd  = rd_q[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt  <= '0;
         rd_q <= '0;
         wr_q <= '0;
         pend <= '0;
         resv <= '0;
      end else begin
         for (int i = 0; i < 5; i++) begin
            if (fu_en[i]) begin
               cnt[i]  <= LATS[i];
               rd_q[i] <= issue_rd;
               wr_q[i] <= cand_wr;
            end else if (cnt[i] != 5'd0) begin
               cnt[i] <= cnt[i] - 5'd1;
            end
         end
         pend <= (pend & ~(wb_we ? 32'd1 << wb_rd : 32'd0)) | (acc_wr ? 32'd1 << issue_rd : 32'd0);
         resv <= (resv >> 1) | (acc_wr ? 32'd1 << (lat_sel - 5'd1) : 32'd0);
      end
   end

`ifdef FU_SB_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_cnt <= '0;
      else if (issue_valid && !issue_ok && stall_cnt != 32'hFFFF_FFFF)
         stall_cnt <= stall_cnt + 32'd1;
   end
`else
   assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_fu_scoreboard.sv
// tb_fu_scoreboard: directed and random issue streams checked against a
// time-indexed model (absolute FU free times, pending-until times, writeback calendar).
module tb_fu_scoreboard;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        issue_valid = 1'b0;
   logic [2:0]  issue_fu = 3'd0;
   logic [4:0]  issue_rd = 5'd0;
   logic        issue_wr = 1'b0;
   logic [4:0]  issue_rs1 = 5'd0;
   logic [4:0]  issue_rs2 = 5'd0;
   logic        issue_use_rs1 = 1'b0;
   logic        issue_use_rs2 = 1'b0;
   logic        issue_ok;
   logic [4:0]  fu_en;
   logic [4:0]  busy;
   logic        wb_we;
   logic [2:0]  wb_sel;
   logic [4:0]  wb_rd;
   logic [31:0] stall_cnt;

   fu_scoreboard dut (
      .clk(clk), .rst(rst_n), .issue_valid(issue_valid), .issue_fu(issue_fu),
      .issue_rd(issue_rd), .issue_wr(issue_wr), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2), .issue_ok(issue_ok),
      .fu_en(fu_en), .busy(busy), .wb_we(wb_we), .wb_sel(wb_sel), .wb_rd(wb_rd),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   localparam int MAXC = 8192;
   int lat_m [6] = '{0, 1, 2, 7, 24, 1};
   int fu_t [6];
   int clr_at [32];
   int sel_at [MAXC];
   int rd_at [MAXC];
   int cyc = 0;
   int stall_m = 0;
   int checks = 0;
   int errors = 0;
   bit last_ok = 1'b0;

   function automatic bit pending(input int r);
      return r != 0 && cyc < clr_at[r];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 6; i++) fu_t[i] = -1000;
      for (int i = 0; i < 32; i++) clr_at[i] = 0;
      for (int i = 0; i < MAXC; i++) begin
         sel_at[i] = 0;
         rd_at[i] = 0;
      end
      stall_m = 0;
   endtask

   task automatic tick();
      bit ok;
      int f;
      logic [4:0] eb;
      @(negedge clk);
      f = int'(issue_fu);
      ok = rst_n && issue_valid && f >= 1 && f <= 5;
      if (ok)
         ok = cyc >= fu_t[f] + lat_m[f]
              && !(issue_use_rs1 && pending(int'(issue_rs1)))
              && !(issue_use_rs2 && pending(int'(issue_rs2)))
              && !(issue_wr && pending(int'(issue_rd)))
              && !(issue_wr && issue_rd != 5'd0 && sel_at[cyc + lat_m[f]] != 0);
      eb = '0;
      for (int i = 1; i <= 5; i++) eb[i-1] = cyc > fu_t[i] && cyc <= fu_t[i] + lat_m[i];
      chk("issue_ok", 32'(issue_ok), 32'(ok));
      chk("fu_en", 32'(fu_en), ok ? 32'd1 << (f - 1) : 32'd0);
      chk("busy", 32'(busy), 32'(eb));
      chk("wb_we", 32'(wb_we), 32'(sel_at[cyc] != 0));
      chk("wb_sel", 32'(wb_sel), 32'(sel_at[cyc]));
      chk("wb_rd", 32'(wb_rd), 32'(rd_at[cyc]));
`ifdef FU_SB_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, 32'(stall_m));
`else
      chk("stall_cnt", stall_cnt, 32'd0);
`endif
      if (rst_n && issue_valid && !ok) stall_m++;
      if (ok) begin
         fu_t[f] = cyc;
         if (issue_wr && issue_rd != 5'd0) begin
            sel_at[cyc + lat_m[f]] = f;
            rd_at[cyc + lat_m[f]] = int'(issue_rd);
            clr_at[issue_rd] = cyc + lat_m[f] + 1;
         end
      end
      last_ok = ok;
      @(posedge clk);
      #1;
      cyc++;
      if (cyc > MAXC - 64) begin
         $display("FAIL cycle_budget observed=%0d expected<%0d", cyc, MAXC - 64);
         $fatal(1);
      end
   endtask

   task automatic idle(input int n);
      issue_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_model();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic issue_wait(input int fu, input int rd, input bit wr, input int rs1, input bit u1,
                             input int rs2, input bit u2, input int maxw, output int w);
      issue_valid = 1'b1;
      issue_fu = 3'(fu);
      issue_rd = 5'(rd);
      issue_wr = wr;
      issue_rs1 = 5'(rs1);
      issue_use_rs1 = u1;
      issue_rs2 = 5'(rs2);
      issue_use_rs2 = u2;
      w = 0;
      tick();
      while (!last_ok && w < maxw) begin
         w++;
         tick();
      end
      issue_valid = 1'b0;
   endtask

   initial begin
      int w;
      @(posedge clk);
      #1;
      do_reset();
      issue_wait(1, 5, 1, 0, 0, 0, 0, 10, w);
      chk("alu_first_issue_wait", w, 0);
      idle(4);
      issue_wait(3, 3, 1, 0, 0, 0, 0, 10, w);
      issue_wait(1, 10, 1, 3, 1, 0, 0, 20, w);
      chk("raw_mul_wait", w, 7);
      idle(30);
      issue_wait(4, 8, 1, 0, 0, 0, 0, 10, w);
      idle(22);
      issue_wait(1, 9, 1, 0, 0, 0, 0, 10, w);
      chk("port_conflict_wait", w, 1);
      idle(30);
      issue_wait(3, 1, 1, 0, 0, 0, 0, 10, w);
      issue_wait(3, 2, 1, 0, 0, 0, 0, 20, w);
      chk("mul_b2b_wait", w, 6);
      idle(30);
      issue_wait(2, 7, 0, 0, 0, 0, 0, 10, w);
      issue_wait(1, 4, 1, 0, 0, 0, 0, 10, w);
      chk("store_then_alu_wait", w, 0);
      idle(30);
      issue_wait(4, 6, 1, 0, 0, 0, 0, 10, w);
      idle(9);
      do_reset();
      issue_wait(1, 11, 1, 6, 1, 0, 0, 10, w);
      chk("after_reset_wait", w, 0);
      idle(30);
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(299) == 0) begin
            do_reset();
         end else begin
            issue_valid = $urandom_range(9) < 7;
            issue_fu = 3'($urandom_range(7));
            issue_rd = 5'($urandom_range(7));
            issue_wr = $urandom_range(3) != 0;
            issue_rs1 = 5'($urandom_range(7));
            issue_rs2 = 5'($urandom_range(7));
            issue_use_rs1 = 1'($urandom_range(1));
            issue_use_rs2 = 1'($urandom_range(1));
            tick();
         end
      end
      idle(30);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
